// File: rtl/alu_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared types and constants for the ALU arbiter: FSM state
//               encoding, ALU operation encoding and NZCV flag bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // ALU operation encoding as seen on req_ctrl / alu_ctrl
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after prio_ptr (wrapping modulo NREQ) as a
//               one-hot grant plus its encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] prio_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx
);

  // One extra bit so prio_ptr + offset never overflows before the wrap
  logic [IDXW:0] slot;
  logic          found;

  // Scan from prio_ptr upward and stop at the first valid requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = '0;
    for (int i = 0; i < NREQ; i++) begin
      slot = {1'b0, prio_ptr} + (IDXW+1)'(i);
      if (slot >= (IDXW+1)'(NREQ)) begin
        slot = slot - (IDXW+1)'(NREQ);
      end
      if (!found && req[slot[IDXW-1:0]]) begin
        found                   = 1'b1;
        grant[slot[IDXW-1:0]]   = 1'b1;
        grant_idx               = slot[IDXW-1:0];
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational 32-bit ALU between NREQ requesters.
//               Accepts one operation at a time (valid/ready, round-robin),
//               drives the ALU from registered operands, captures the result
//               and NZCV flags, and holds the response until the owner
//               acknowledges it.
//               Optional feature macro ALU_ARBITER_LOCK_EN adds req_lock,
//               which keeps priority on the current owner after its
//               response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 32,
  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  input  logic [NREQ-1:0][1:0]        req_ctrl,
`ifdef ALU_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]             req_lock,
`endif
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [1:0]                  alu_ctrl,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic [3:0]                  alu_flags,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [WIDTH-1:0]            rsp_result,
  output logic [3:0]                  rsp_flags
);

  state_e           state_q,    state_d;
  logic [IDXW-1:0]  prio_ptr_q, prio_ptr_d;
  logic [IDXW-1:0]  owner_q,    owner_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  alu_op_e          ctrl_q,     ctrl_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [3:0]       flags_q,    flags_d;

  logic [NREQ-1:0]  grant;
  logic [IDXW-1:0]  grant_idx;
  logic [IDXW-1:0]  next_ptr;

  rr_arbiter #(
    .NREQ      (NREQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .prio_ptr  (prio_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Priority after a completed operation: next requester, or stay on a locked owner
  always_comb begin
    next_ptr = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + IDXW'(1);
`ifdef ALU_ARBITER_LOCK_EN
    if (req_lock[owner_q]) begin
      next_ptr = owner_q;
    end
`endif
  end

  // Next-state, register loads and handshake outputs
  always_comb begin
    state_d    = state_q;
    prio_ptr_d = prio_ptr_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    flags_d    = flags_q;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_q)
      ST_IDLE: begin
        // Ready is suppressed while reset is asserted so the reset view is clean
        req_ready = reset_n ? grant : '0;
        if (|grant) begin
          owner_d = grant_idx;
          a_d     = req_a[grant_idx];
          b_d     = req_b[grant_idx];
          ctrl_d  = alu_op_e'(req_ctrl[grant_idx]);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d        = alu_result;
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          prio_ptr_d = next_ptr;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      prio_ptr_q <= '0;
      owner_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= OP_ADD;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter (NREQ=2, WIDTH=32) with a
//               behavioural ALU, a vector table and a response scoreboard.
//               Lock sequence runs when ALU_ARBITER_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic             clk;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][1:0]  req_ctrl;
`ifdef ALU_ARBITER_LOCK_EN
  logic [1:0]       req_lock;
`endif
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [1:0]       alu_ctrl;
  logic [31:0]      alu_result;
  logic [3:0]       alu_flags;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [35:0]      alu_bus;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  alu_arbiter #(
    .NREQ       (2),
    .WIDTH      (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
`ifdef ALU_ARBITER_LOCK_EN
    .req_lock   (req_lock),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: returns {N,Z,C,V,result}; C is carry-out (no-borrow on SUB)
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb alu_bus = alu_ref(alu_a, alu_b, alu_ctrl);
  assign alu_flags  = alu_bus[35:32];
  assign alu_result = alu_bus[31:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, expected DUT event (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   mon_w;

  always @(negedge clk) begin
    if (reset_n) begin
      if (|(req_ready & req_valid)) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        mon_w = 0;
        for (int i = 0; i < 2; i++) if (req_ready[i]) mon_w = i;
        mon_e.owner = mon_w;
        {mon_e.flg, mon_e.res} = alu_ref(req_a[mon_w], req_b[mon_w], req_ctrl[mon_w]);
        sb.push_back(mon_e);
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin
          timeout("sb_unexpected_response");
        end else begin
          mon_e = sb.pop_front();
          chk("sb_owner",  32'(rsp_valid),  32'(2'b01 << mon_e.owner));
          chk("sb_result", rsp_result,      mon_e.res);
          chk("sb_flags",  32'(rsp_flags),  32'(mon_e.flg));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ctrl;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;
  vec_t vecs[8];

  task automatic drive_at_edge();
    @(posedge clk);
    #2;
  endtask

  // One isolated operation with latency checks against table constants
  task automatic run_vec(input vec_t v);
    bit got;
    drive_at_edge();
    req_valid[v.idx] = 1'b1;
    req_a[v.idx]     = v.a;
    req_b[v.idx]     = v.b;
    req_ctrl[v.idx]  = v.ctrl;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready[v.idx]) got = 1'b1;
    end
    if (!got) begin
      timeout("vec_accept");
      req_valid = '0;
      return;
    end
    drive_at_edge();
    req_valid[v.idx] = 1'b0;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu_a",     alu_a,          v.a);
    chk("exec_alu_b",     alu_b,          v.b);
    chk("exec_alu_ctrl",  32'(alu_ctrl),  32'(v.ctrl));
    @(negedge clk);
    chk("vec_rsp_valid",  32'(rsp_valid), 32'(2'b01 << v.idx));
    chk("vec_result",     rsp_result,     v.res);
    chk("vec_flags",      32'(rsp_flags), 32'(v.flg));
    drive_at_edge();
    rsp_ready[v.idx] = 1'b1;
    drive_at_edge();
    rsp_ready = '0;
  endtask

  task automatic wait_grant(output int w, output int at);
    w  = -1;
    at = 0;
    for (int t = 0; t < 20 && w < 0; t++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        at = cyc;
        for (int i = 0; i < 2; i++) if (req_ready[i]) w = i;
      end
    end
    if (w < 0) timeout("grant_wait");
  endtask

  task automatic do_reset();
    drive_at_edge();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  int w;
  int at;
  int prev_at;
  int exp_order[3];

  initial begin
    vecs[0] = '{0, 32'd5,        32'd3,        2'b01, 32'h0000_0002, 4'b0010};
    vecs[1] = '{1, 32'd7,        32'd7,        2'b01, 32'h0000_0000, 4'b0110};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'd1,       2'b00, 32'h0000_0000, 4'b0110};
    vecs[3] = '{1, 32'h7FFF_FFFF, 32'd1,       2'b00, 32'h8000_0000, 4'b1001};
    vecs[4] = '{0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF000_F000, 4'b1000};
    vecs[5] = '{1, 32'h0000_0000, 32'h0000_0000, 2'b11, 32'h0000_0000, 4'b0100};
    vecs[6] = '{1, 32'd3,        32'd5,        2'b01, 32'hFFFF_FFFE, 4'b1000};
    vecs[7] = '{0, 32'h1234_0000, 32'h0000_5678, 2'b11, 32'h1234_5678, 4'b0000};

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    rsp_ready = '0;
`ifdef ALU_ARBITER_LOCK_EN
    req_lock  = '0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_alu_a",      alu_a,           32'd0);
    chk("rst_alu_b",      alu_b,           32'd0);
    chk("rst_alu_ctrl",   32'(alu_ctrl),   32'd0);
    chk("rst_rsp_result", rsp_result,      32'd0);
    chk("rst_rsp_flags",  32'(rsp_flags),  32'd0);
    drive_at_edge();
    reset_n = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: req0 response held 5 cycles while req1 waits; non-owner ack ignored
    drive_at_edge();
    req_valid[0] = 1'b1; req_a[0] = 32'd9; req_b[0] = 32'd4; req_ctrl[0] = OP_SUB;
    wait_grant(w, at);
    chk("bp_grant", 32'(w), 32'd0);
    drive_at_edge();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_a[1] = 32'd1; req_b[1] = 32'd2; req_ctrl[1] = OP_ADD;
    rsp_ready    = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'b01);
      chk("bp_result",    rsp_result,     32'd5);
      chk("bp_flags",     32'(rsp_flags), 32'b0010);
      chk("bp_no_ready",  32'(req_ready), 32'd0);
    end
    drive_at_edge();
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_ready_in_hs_cycle", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_after_hs",    32'(req_ready), 32'b10);
    drive_at_edge();
    req_valid = '0;
    repeat (4) @(negedge clk);
    drive_at_edge();
    rsp_ready = '0;

    // Reset during EXEC: priority would otherwise sit on req1
    run_vec('{0, 32'hFFFF_FFFF, 32'd2, 2'b00, 32'h0000_0001, 4'b0010});
    drive_at_edge();
    req_valid[0] = 1'b1; req_a[0] = 32'd1; req_b[0] = 32'd1; req_ctrl[0] = OP_SUB;
    wait_grant(w, at);
    drive_at_edge();
    req_valid = 2'b11;
    req_a[1] = 32'd40; req_b[1] = 32'd2; req_ctrl[1] = OP_OR;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_req_ready",  32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid",  32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a",      alu_a,          32'd0);
    chk("mid_rst_alu_b",      alu_b,          32'd0);
    chk("mid_rst_alu_ctrl",   32'(alu_ctrl),  32'd0);
    chk("mid_rst_rsp_result", rsp_result,     32'd0);
    chk("mid_rst_rsp_flags",  32'(rsp_flags), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant",     32'(req_ready), 32'b01);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    drive_at_edge();
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (4) @(negedge clk);
    drive_at_edge();
    rsp_ready = '0;

    // Both requesters valid continuously, responses always accepted
    do_reset();
    req_a[0] = 32'd10;  req_b[0] = 32'd20;  req_ctrl[0] = OP_ADD;
    req_a[1] = 32'd100; req_b[1] = 32'd200; req_ctrl[1] = OP_ADD;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    exp_order = '{0, 1, 0};
    prev_at = 0;
    for (int i = 0; i < 3; i++) begin
      wait_grant(w, at);
      chk("rr_order", 32'(w), 32'(exp_order[i]));
      if (i > 0) chk("rr_gap", 32'(at - prev_at), 32'd3);
      prev_at = at;
    end
    drive_at_edge();
    req_valid = '0;
    repeat (5) @(negedge clk);
    drive_at_edge();
    rsp_ready = '0;

`ifdef ALU_ARBITER_LOCK_EN
    // Locked owner keeps priority for a second operation
    do_reset();
    req_lock  = 2'b01;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    exp_order = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      wait_grant(w, at);
      chk("lock_order", 32'(w), 32'(exp_order[i]));
      if (i == 1) begin
        drive_at_edge();
        req_lock = 2'b00;
      end
    end
    drive_at_edge();
    req_valid = '0;
    repeat (5) @(negedge clk);
    drive_at_edge();
    rsp_ready = '0;
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_arbiter
`default_nettype wire
